// File: rtl/gbt_xu5_link_core.sv
// gbt_xu5_link_core
//   Frame-level GBT-style link core, single 40 MHz frame clock domain.
//   TX: builds a 120-bit frame {header[3:0], payload[83:0], crc[31:0]} from data_sent.
//   RX: registers rx_frame, removes an unknown left rotation by bitslipping,
//       locks after LOCK_FRAMES consecutive valid frames, returns the payload.
// Ports:
//   clk, reset          frame clock, asynchronous active-high reset
//   data_sent     [83:0]  user payload, sampled every cycle
//   tx_frame     [119:0]  transmitted frame (registered)
//   rx_frame     [119:0]  received frame, arbitrary left rotation of a TX frame
//   sfp_los               optical loss of signal
//   bitslip_reset         restart alignment from slip 0 while high
//   data_received [83:0]  recovered payload
//   link_ready            receiver locked
//   rx_error              one-cycle pulse per invalid frame while locked
//   bitslip_count  [6:0]  current rotation correction, 0..119
module gbt_xu5_link_core #(
    parameter int unsigned LOCK_FRAMES   = 8,
    parameter int unsigned UNLOCK_FRAMES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [83:0]  data_sent,
    output logic [119:0] tx_frame,
    input  logic [119:0] rx_frame,
    input  logic         sfp_los,
    input  logic         bitslip_reset,
    output logic [83:0]  data_received,
    output logic         link_ready,
    output logic         rx_error,
    output logic [6:0]   bitslip_count
);

    localparam logic [3:0] HdrData = 4'b0101;
    localparam logic [3:0] HdrIdle = 4'b0110;
    localparam int unsigned LCW = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned UCW = $clog2(UNLOCK_FRAMES + 1);

    typedef enum logic [1:0] {StLos, StSearch, StConfirm, StLocked} state_t;

    // CRC-32 (0x04C11DB7), init all-ones, MSB first, no reflection, no final XOR.
    function automatic logic [31:0] crc32_88(input logic [87:0] d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 87; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // ---------------------------------------------------------------- TX
    logic         first_q;
    logic [3:0]   tx_hdr;
    logic [83:0]  tx_pay;
    logic [119:0] tx_next;

    always_comb begin
        tx_hdr  = first_q ? HdrIdle : HdrData;
        tx_pay  = first_q ? 84'd0 : data_sent;
        tx_next = {tx_hdr, tx_pay, crc32_88({tx_hdr, tx_pay})};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q  <= 1'b1;
            tx_frame <= '0;
        end else begin
            first_q  <= 1'b0;
            tx_frame <= tx_next;
        end
    end

    // ---------------------------------------------------------------- RX
    logic [119:0]   rx_q;
    logic [119:0]   aligned;
    logic           rx_valid;
    logic           rx_empty;
    logic           rx_is_data;
    logic [6:0]     slip_next;
    state_t         state_q;
    logic [LCW-1:0] lock_cnt_q;
    logic [UCW-1:0] inv_cnt_q;

    always_comb begin
        // Rotate right; a zero left shift by 120 yields 0, so count 0 passes rx_q through.
        aligned    = (rx_q >> bitslip_count) | (rx_q << (7'd120 - bitslip_count));
        rx_is_data = (aligned[119:116] == HdrData);
        rx_valid   = (rx_is_data || (aligned[119:116] == HdrIdle)) &&
                     (crc32_88(aligned[119:32]) == aligned[31:0]);
        // An all-zero word is a dead line, not a misaligned frame: don't slip on it.
        rx_empty   = (rx_q == '0);
        slip_next  = (bitslip_count == 7'd119) ? 7'd0 : bitslip_count + 7'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q          <= '0;
            state_q       <= StSearch;
            lock_cnt_q    <= '0;
            inv_cnt_q     <= '0;
            bitslip_count <= '0;
            data_received <= '0;
            link_ready    <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            rx_q     <= rx_frame;
            rx_error <= 1'b0;
            if (sfp_los) begin
                state_q       <= StLos;
                lock_cnt_q    <= '0;
                inv_cnt_q     <= '0;
                data_received <= '0;
                link_ready    <= 1'b0;
            end else if (bitslip_reset) begin
                state_q       <= StSearch;
                bitslip_count <= '0;
                lock_cnt_q    <= '0;
                inv_cnt_q     <= '0;
                data_received <= '0;
                link_ready    <= 1'b0;
            end else begin
                unique case (state_q)
                    StLos: begin
                        state_q <= StSearch;
                    end
                    StSearch: begin
                        if (rx_valid) begin
                            state_q    <= StConfirm;
                            lock_cnt_q <= LCW'(1);
                        end else if (!rx_empty) begin
                            bitslip_count <= slip_next;
                        end
                    end
                    StConfirm: begin
                        if (rx_valid) begin
                            lock_cnt_q <= lock_cnt_q + LCW'(1);
                            if (lock_cnt_q >= LCW'(LOCK_FRAMES - 1)) begin
                                state_q    <= StLocked;
                                link_ready <= 1'b1;
                                inv_cnt_q  <= '0;
                            end
                        end else begin
                            state_q       <= StSearch;
                            lock_cnt_q    <= '0;
                            bitslip_count <= slip_next;
                        end
                    end
                    StLocked: begin
                        if (rx_valid) begin
                            inv_cnt_q <= '0;
                            if (rx_is_data) data_received <= aligned[115:32];
                        end else begin
                            rx_error <= 1'b1;
                            if (inv_cnt_q >= UCW'(UNLOCK_FRAMES - 1)) begin
                                // Keep bitslip_count: the old alignment is the best first guess.
                                state_q       <= StSearch;
                                inv_cnt_q     <= '0;
                                lock_cnt_q    <= '0;
                                data_received <= '0;
                                link_ready    <= 1'b0;
                            end else begin
                                inv_cnt_q <= inv_cnt_q + UCW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gbt_xu5_link_core.sv
`timescale 1ns/100ps
module tb_gbt_xu5_link_core;

    logic         clk = 1'b0;
    logic         reset;
    logic [83:0]  data_sent;
    logic [119:0] tx_frame;
    logic [119:0] rx_frame;
    logic         sfp_los;
    logic         bitslip_reset;
    logic [83:0]  data_received;
    logic         link_ready;
    logic         rx_error;
    logic [6:0]   bitslip_count;

    int           rot;
    logic [119:0] flip;
    int           total = 0;
    int           bad   = 0;

    localparam logic [83:0]  D0   = 84'hc000babeac1dacdcfffff;
    localparam logic [83:0]  D1   = 84'h123456789abcdef012345;
    localparam logic [83:0]  D2   = 84'hfedcba9876543210fedcb;
    localparam logic [119:0] MASK = 120'd1 << 60;

    always #12.5 clk = ~clk;

    function automatic logic [119:0] rotl(input logic [119:0] f, input int r);
        logic [239:0] d;
        d = {f, f} << r;
        return d[239:120];
    endfunction

    // Reference CRC-32/MPEG-2 style: feed each bit into the top, then reduce.
    function automatic logic [31:0] ref_crc(input logic [87:0] d);
        logic [31:0] c;
        c = '1;
        for (int i = 87; i >= 0; i--) begin
            c = c ^ {d[i], 31'd0};
            c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [119:0] mk_frame(input logic [3:0] h, input logic [83:0] p);
        return {h, p, ref_crc({h, p})};
    endfunction

    assign rx_frame = rotl(tx_frame, rot) ^ flip;

    gbt_xu5_link_core #(.LOCK_FRAMES(8), .UNLOCK_FRAMES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_sent     (data_sent),
        .tx_frame      (tx_frame),
        .rx_frame      (rx_frame),
        .sfp_los       (sfp_los),
        .bitslip_reset (bitslip_reset),
        .data_received (data_received),
        .link_ready    (link_ready),
        .rx_error      (rx_error),
        .bitslip_count (bitslip_count)
    );

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step negedges until link_ready reaches lvl or the budget runs out.
    task automatic wait_ready(input logic lvl, input int limit, output int cycles);
        cycles = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            cycles = c;
            if (link_ready === lvl) break;
        end
    endtask

    initial begin
        int          cyc;
        int          errs;
        logic        seen;
        logic [83:0] hist [0:15];

        reset = 1'b1; data_sent = D0; sfp_los = 1'b0; bitslip_reset = 1'b0;
        rot = 0; flip = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_frame", tx_frame, 120'd0);
        chk("rst_data_received", data_received, 120'd0);
        chk("rst_link_ready", link_ready, 120'd0);
        chk("rst_rx_error", rx_error, 120'd0);
        chk("rst_bitslip_count", bitslip_count, 120'd0);

        // Zero rotation
        reset = 1'b0;
        @(negedge clk);
        chk("first_frame_idle", tx_frame, mk_frame(4'b0110, 84'd0));
        wait_ready(1'b1, 20, cyc);
        chk("rot0_ready", link_ready, 120'd1);
        chk("rot0_lock_within_10", (cyc + 1) <= 10, 120'd1);
        chk("rot0_slip", bitslip_count, 120'd0);
        repeat (2) @(negedge clk);
        chk("rot0_data", data_received, D0);
        chk("tx_data_frame", tx_frame, mk_frame(4'b0101, D0));

        // Rotation 37
        rot = 37;
        wait_ready(1'b0, 10, cyc);
        chk("rot37_drop", link_ready, 120'd0);
        wait_ready(1'b1, 100, cyc);
        chk("rot37_ready", link_ready, 120'd1);
        chk("rot37_slip", bitslip_count, 120'd37);

        // Incrementing data, 3-cycle loopback latency
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= 3) chk("inc_data", data_received, hist[i-3]);
            errs += int'(rx_error);
            hist[i]   = {20'h0, 32'h1000 + i, 32'h1000 + i};
            data_sent = hist[i];
            @(negedge clk);
        end
        chk("inc_no_rx_error", errs, 120'd0);

        // Loss of signal for 10 us
        sfp_los = 1'b1;
        @(negedge clk);
        chk("los_drop", link_ready, 120'd0);
        seen = 1'b0;
        repeat (399) begin
            @(negedge clk);
            if (link_ready !== 1'b0) seen = 1'b1;
        end
        chk("los_ready_low", seen, 120'd0);
        sfp_los = 1'b0;
        wait_ready(1'b1, 60, cyc);
        chk("los_relock", link_ready, 120'd1);
        chk("los_relock_time", cyc <= 46, 120'd1);
        chk("los_slip_held", bitslip_count, 120'd37);

        // Three corrupted frames while locked
        data_sent = D1;
        repeat (5) @(negedge clk);
        chk("pre_corrupt_data", data_received, D1);
        data_sent = D2;
        errs = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            errs += int'(rx_error);
            if (link_ready !== 1'b1) seen = 1'b1;
            flip = (i < 3) ? MASK : '0;
            if (i == 4) chk("corrupt3_hold", data_received, D1);
            @(negedge clk);
        end
        chk("corrupt3_pulses", errs, 120'd3);
        chk("corrupt3_ready_kept", seen, 120'd0);
        chk("corrupt3_recover", data_received, D2);

        // Four corrupted frames drop the lock
        for (int i = 0; i < 6; i++) begin
            flip = (i < 4) ? MASK : '0;
            if (i == 5) begin
                chk("corrupt4_unlock", link_ready, 120'd0);
                chk("corrupt4_data_clr", data_received, 120'd0);
            end
            @(negedge clk);
        end
        wait_ready(1'b1, 30, cyc);
        chk("corrupt4_relock", link_ready, 120'd1);
        chk("corrupt4_slip", bitslip_count, 120'd37);

        // Bitslip reset while locked
        bitslip_reset = 1'b1;
        @(negedge clk);
        chk("bsr_slip0", bitslip_count, 120'd0);
        chk("bsr_unlock", link_ready, 120'd0);
        bitslip_reset = 1'b0;
        wait_ready(1'b1, 80, cyc);
        chk("bsr_relock", link_ready, 120'd1);
        chk("bsr_slip37", bitslip_count, 120'd37);

        // Asynchronous reset between edges
        repeat (3) @(negedge clk);
        @(posedge clk);
        #5 reset = 1'b1;
        #1;
        chk("areset_tx", tx_frame, 120'd0);
        chk("areset_ready", link_ready, 120'd0);
        chk("areset_data", data_received, 120'd0);
        chk("areset_slip", bitslip_count, 120'd0);
        chk("areset_rx_error", rx_error, 120'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("areset_first_hdr", tx_frame[119:116], 120'h6);
        chk("areset_first_frame", tx_frame, mk_frame(4'b0110, 84'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
